race_game_ctrl: RTL and testbench
=================================

Name: race_game_ctrl

Overview:
- Top-level sequencer for the pyonpyon race.
- Owns the game FSM: idle, load, play and done.
- Gates the run enables of the seconds timer and the PC score countdown, and drives load/shift of the 33-bit box shifter.
- Validates player key presses against the next box and declares the winner; sits between the switches/keys and the counter/shifter datapath.

Parameters:
- BOX_COUNT, 32, boxes the player must clear; also the reload value of player_left.
- TIME_LIMIT, 99, seconds of play before timeout.
- PENALTY_CYCLES, 25000000, lockout length in clocks after a wrong key (used only with the optional feature).

Ports:
- clock  in  1  system clock (CLOCK_50)
- resetn  in  1  synchronous, active-low reset
- start  in  1  game run switch, level, asynchronous to clock
- key_left  in  1  raw left key, active-high, asynchronous
- key_right  in  1  raw right key, active-high, asynchronous
- next_box  in  1  shifter head bit: 0 = left, 1 = right
- pc_done  in  1  PC countdown reached zero (level)
- sec_tick  in  1  one-cycle 1 Hz pulse from the timer rate divider
- cnt_clr_n  out  1  active-low clear to the timer and PC counters
- timer_en  out  1  run enable, timer
- pc_en  out  1  run enable, PC counter
- shift_load_n  out  1  active-low parallel load of the box shifter
- shift_en  out  1  one-cycle shift pulse to the box shifter
- player_left  out  6  boxes remaining for the player
- winner  out  2  00 none, 01 player, 10 PC, 11 timeout
- game_state  out  2  00 IDLE, 01 LOAD, 10 PLAY, 11 DONE

Behaviour:
- All registers reset on clock edge when resetn=0. Reset values: game_state=IDLE, cnt_clr_n=0, shift_load_n=0, timer_en=0, pc_en=0, shift_en=0, player_left=BOX_COUNT, winner=00, elapsed=0.
- Inputs start, key_left and key_right each pass a 2-flop synchronizer. Key rising edges are detected on the synchronized value, giving a 3-cycle latency from raw input to edge.
- IDLE:
  - cnt_clr_n=0, shift_load_n=0, enables low.
  - Synchronized start=1 -> LOAD.
- LOAD (exactly 1 cycle):
  - shift_load_n=0, cnt_clr_n=0, player_left<=BOX_COUNT, elapsed<=0, winner<=00.
  - Next state PLAY.
- PLAY:
  - cnt_clr_n=1, shift_load_n=1, timer_en=1, pc_en=1.
  - Key edge, exactly one key, shift_en currently 0, and the key matches next_box (left and next_box=0, or right and next_box=1): shift_en=1 on the next cycle and player_left decrements on that same edge.
  - Key edges arriving while shift_en=1 are ignored.
  - Both key edges in the same cycle count as wrong.
  - A wrong key has no effect unless the optional feature is enabled.
  - elapsed increments on sec_tick.
- Exit from PLAY, by priority on the same cycle:
  1. player_left decrementing 1->0 -> DONE, winner=01.
  2. pc_done=1 -> DONE, winner=10.
  3. elapsed reaching TIME_LIMIT -> DONE, winner=11.
  - Player wins all ties.
- Synchronized start=0 in PLAY aborts to IDLE with winner=00.
- DONE:
  - Enables low, cnt_clr_n=1 so displays freeze, shift_en=0.
  - winner and player_left are held.
  - start=0 -> IDLE.
- player_left saturates at 0 and never wraps. shift_en is never asserted outside PLAY.
- Reset asserted mid-game returns every output to its reset value on the next clock edge.

Optional Feature:
- Macro: RACE_PENALTY_EN.
- When defined:
  - A wrong key in PLAY loads a lockout counter with PENALTY_CYCLES.
  - While the counter is nonzero, all key edges are ignored.
  - The counter clears on LOAD and on reset.
- When undefined:
  - Wrong keys are silently ignored.
  - No lockout counter is synthesized.

Decomposition:
- Package race_pkg holds:
  - state encodings IDLE/LOAD/PLAY/DONE;
  - winner encodings WIN_NONE/WIN_PLAYER/WIN_PC/WIN_TIMEOUT;
  - default BOX_COUNT and TIME_LIMIT constants.
- Sub-module key_edge_sync (2-flop synchronizer plus rising-edge pulse), instantiated twice for the keys; start uses the synchronizer path only.

Test Plan:
- Reset, raise start -> LOAD for 1 cycle, then PLAY with timer_en=pc_en=1, player_left=32, shift_load_n=0 during IDLE/LOAD.
- next_box=1, press right -> shift_en pulses for exactly 1 cycle 4 cycles after the raw edge, player_left=31. Then press left with next_box=1 -> no shift, player_left stays 31.
- 32 correct presses with pc_done held 0 -> player_left=0, DONE, winner=01, enables low, shift_en never pulses again.
- Assert pc_done on the same cycle as the 32nd correct shift -> winner=01. pc_done alone with player_left=5 -> winner=10.
- Set TIME_LIMIT=3, pulse sec_tick 3 times with no keys -> DONE, winner=11. Drop start -> IDLE, cnt_clr_n=0.
- With RACE_PENALTY_EN and PENALTY_CYCLES=10, press the wrong key and then the correct key within 10 cycles -> no shift; the correct key after the lockout expires -> shift_en pulse.

Source files
------------

// File: rtl/race_pkg.sv
// Shared encodings and default sizing for the pyonpyon race controller.
package race_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        PLAY = 2'b10,
        DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE    = 2'b00,
        WIN_PLAYER  = 2'b01,
        WIN_PC      = 2'b10,
        WIN_TIMEOUT = 2'b11
    } winner_e;

    localparam int DEF_BOX_COUNT      = 32;
    localparam int DEF_TIME_LIMIT     = 99;
    localparam int DEF_PENALTY_CYCLES = 25000000;

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer for a raw key followed by a registered rising-edge pulse.
module key_edge_sync (
    input  logic clock,
    input  logic resetn,
    input  logic raw_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic edge_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            edge_q <= sync_q & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/race_game_ctrl.sv
// Game sequencer for the pyonpyon race: FSM, key validation and winner decision.
// Optional wrong-key lockout is built when RACE_PENALTY_EN is defined.
module race_game_ctrl
    import race_pkg::*;
#(
    parameter int BOX_COUNT      = DEF_BOX_COUNT,
    parameter int TIME_LIMIT     = DEF_TIME_LIMIT,
    parameter int PENALTY_CYCLES = DEF_PENALTY_CYCLES
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       next_box,
    input  logic       pc_done,
    input  logic       sec_tick,
    output logic       cnt_clr_n,
    output logic       timer_en,
    output logic       pc_en,
    output logic       shift_load_n,
    output logic       shift_en,
    output logic [5:0] player_left,
    output logic [1:0] winner,
    output logic [1:0] game_state
);

    localparam int EW = $clog2(TIME_LIMIT + 1);
    localparam int LW = $clog2(PENALTY_CYCLES + 1);

    logic start_meta_q;
    logic start_sync_q;
    logic left_edge;
    logic right_edge;

    state_e     state_q, state_d;
    winner_e    winner_q, winner_d;
    logic [5:0] player_left_q, player_left_d;
    logic [EW-1:0] elapsed_q, elapsed_d;
    logic       shift_en_q, shift_en_d;

    logic          key_live;
    logic          key_match;
    logic          key_ok;
    logic [LW-1:0] lock_q;
    logic          locked;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
        end else begin
            start_meta_q <= start;
            start_sync_q <= start_meta_q;
        end
    end

    key_edge_sync u_key_left (
        .clock  (clock),
        .resetn (resetn),
        .raw_i  (key_left),
        .edge_o (left_edge)
    );

    key_edge_sync u_key_right (
        .clock  (clock),
        .resetn (resetn),
        .raw_i  (key_right),
        .edge_o (right_edge)
    );

    // A press is only considered while playing and while no shift is in flight.
    assign key_live  = (left_edge | right_edge) && !shift_en_q && !locked && (state_q == PLAY);
    assign key_match = (left_edge ^ right_edge) && (right_edge == next_box);
    assign key_ok    = key_live && key_match;
    assign locked    = |lock_q;

`ifdef RACE_PENALTY_EN
    always_ff @(posedge clock) begin
        if (!resetn || state_q == LOAD) begin
            lock_q <= '0;
        end else if (key_live && !key_match) begin
            lock_q <= LW'(PENALTY_CYCLES);
        end else if (locked) begin
            lock_q <= lock_q - LW'(1);
        end
    end
`else
    assign lock_q = '0;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= IDLE;
            winner_q      <= WIN_NONE;
            player_left_q <= 6'(BOX_COUNT);
            elapsed_q     <= '0;
            shift_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            player_left_q <= player_left_d;
            elapsed_q     <= elapsed_d;
            shift_en_q    <= shift_en_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        player_left_d = player_left_q;
        elapsed_d     = elapsed_q;
        shift_en_d    = 1'b0;
        cnt_clr_n     = 1'b0;
        shift_load_n  = 1'b0;
        timer_en      = 1'b0;
        pc_en         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_sync_q) state_d = LOAD;
            end
            LOAD: begin
                player_left_d = 6'(BOX_COUNT);
                elapsed_d     = '0;
                winner_d      = WIN_NONE;
                state_d       = PLAY;
            end
            PLAY: begin
                cnt_clr_n    = 1'b1;
                shift_load_n = 1'b1;
                timer_en     = 1'b1;
                pc_en        = 1'b1;
                if (key_ok && player_left_q != 6'd0) player_left_d = player_left_q - 6'd1;
                if (sec_tick) elapsed_d = elapsed_q + EW'(1);

                // Player beats the PC, which beats the clock, on a shared cycle.
                if (!start_sync_q) begin
                    state_d  = IDLE;
                    winner_d = WIN_NONE;
                end else if (key_ok && player_left_q == 6'd1) begin
                    state_d  = DONE;
                    winner_d = WIN_PLAYER;
                end else if (pc_done) begin
                    state_d  = DONE;
                    winner_d = WIN_PC;
                end else if (sec_tick && elapsed_q == EW'(TIME_LIMIT - 1)) begin
                    state_d  = DONE;
                    winner_d = WIN_TIMEOUT;
                end
                shift_en_d = key_ok && (state_d == PLAY);
            end
            DONE: begin
                cnt_clr_n    = 1'b1;
                shift_load_n = 1'b1;
                if (!start_sync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign shift_en    = shift_en_q;
    assign player_left = player_left_q;
    assign winner      = winner_q;
    assign game_state  = state_q;

endmodule

// File: tb/tb_race_game_ctrl.sv
// Self-checking bench for race_game_ctrl against a transaction-level game model.
// Build with RACE_PENALTY_EN defined to exercise the wrong-key lockout.
module tb_race_game_ctrl;

    localparam int BOXES   = 32;
    localparam int TLIMIT  = 3;
    localparam int PENALTY = 10;

    localparam int S_IDLE = 0, S_LOAD = 1, S_PLAY = 2, S_DONE = 3;
    localparam int W_NONE = 0, W_PLAYER = 1, W_PC = 2, W_TIME = 3;

    logic       clock = 1'b0;
    logic       resetn, start, key_left, key_right, next_box, pc_done, sec_tick;
    logic       cnt_clr_n, timer_en, pc_en, shift_load_n, shift_en;
    logic [5:0] player_left;
    logic [1:0] winner, game_state;

    int checks = 0;
    int errors = 0;
    int m_state, m_left, m_winner;

    race_game_ctrl #(
        .BOX_COUNT      (BOXES),
        .TIME_LIMIT     (TLIMIT),
        .PENALTY_CYCLES (PENALTY)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .key_left     (key_left),
        .key_right    (key_right),
        .next_box     (next_box),
        .pc_done      (pc_done),
        .sec_tick     (sec_tick),
        .cnt_clr_n    (cnt_clr_n),
        .timer_en     (timer_en),
        .pc_en        (pc_en),
        .shift_load_n (shift_load_n),
        .shift_en     (shift_en),
        .player_left  (player_left),
        .winner       (winner),
        .game_state   (game_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs implied by the model's view of the game.
    task automatic check_model(input string tag);
        bit running;
        bit active;
        running = (m_state == S_PLAY);
        active  = (m_state == S_PLAY) || (m_state == S_DONE);
        chk({tag, "_state"}, game_state, m_state);
        chk({tag, "_winner"}, winner, m_winner);
        chk({tag, "_left"}, player_left, m_left);
        chk({tag, "_timer_en"}, timer_en, running);
        chk({tag, "_pc_en"}, pc_en, running);
        chk({tag, "_cnt_clr_n"}, cnt_clr_n, active);
        if (m_state != S_DONE) chk({tag, "_shift_load_n"}, shift_load_n, running);
    endtask

    task automatic wait_state(input int exp, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (game_state == exp[1:0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic begin_game();
        bit ok;
        start = 1'b1;
        wait_state(S_LOAD, 10, ok);
        chk("load_reached", ok, 1);
        chk("load_shift_load_n", shift_load_n, 0);
        chk("load_cnt_clr_n", cnt_clr_n, 0);
        chk("load_timer_en", timer_en, 0);
        tick();
        m_state  = S_PLAY;
        m_left   = BOXES;
        m_winner = W_NONE;
        check_model("play_entry");
    endtask

    task automatic end_game();
        bit ok;
        start = 1'b0;
        wait_state(S_IDLE, 10, ok);
        chk("idle_reached", ok, 1);
        if (m_state == S_PLAY) m_winner = W_NONE;
        m_state = S_IDLE;
        check_model("idle");
    endtask

    // One key press: raw key held two cycles, shift_en watched for eight.
    task automatic do_press(input bit kl, input bit kr, input bit nb, input bit pc_at_decision);
        int  pulses;
        int  first;
        int  exp_pulses;
        bit  match;
        bit  wrong;
        pulses    = 0;
        first     = 0;
        next_box  = nb;
        key_left  = kl;
        key_right = kr;
        for (int c = 1; c <= 8; c++) begin
            if (pc_at_decision && c == 4) pc_done = 1'b1;
            tick();
            if (c == 4) pc_done = 1'b0;
            if (c == 2) begin
                key_left  = 1'b0;
                key_right = 1'b0;
            end
            if (shift_en) begin
                pulses++;
                if (first == 0) first = c;
            end
        end

        match      = (m_state == S_PLAY) && (kl != kr) && (kr == nb);
        wrong      = (m_state == S_PLAY) && !match;
        exp_pulses = 0;
        if (match && m_left == 1) begin
            m_left   = 0;
            m_state  = S_DONE;
            m_winner = W_PLAYER;
        end else if (match) begin
            m_left     = m_left - 1;
            exp_pulses = 1;
        end else if (pc_at_decision && m_state == S_PLAY) begin
            m_state  = S_DONE;
            m_winner = W_PC;
        end

        $display("press L=%0d R=%0d box=%0d pc=%0d pulses=%0d at=%0d left=%0d state=%0d winner=%0d",
                 kl, kr, nb, pc_at_decision, pulses, first, player_left, game_state, winner);
        chk("press_pulses", pulses, exp_pulses);
        if (exp_pulses == 1) chk("press_latency", first, 4);
        check_model("press");
`ifdef RACE_PENALTY_EN
        if (wrong) repeat (PENALTY + 2) tick();
`else
        if (wrong) tick();
`endif
    endtask

    task automatic correct_press(input bit pc_at_decision);
        bit nb;
        nb = 1'($urandom_range(0, 1));
        do_press(!nb, nb, nb, pc_at_decision);
    endtask

    initial begin
        int  sel;
        bit  nb;
        int  guard;
        resetn    = 1'b0;
        start     = 1'b0;
        key_left  = 1'b0;
        key_right = 1'b0;
        next_box  = 1'b0;
        pc_done   = 1'b0;
        sec_tick  = 1'b0;
        repeat (3) tick();
        m_state  = S_IDLE;
        m_left   = BOXES;
        m_winner = W_NONE;
        check_model("reset");
        chk("reset_shift_en", shift_en, 0);
        resetn = 1'b1;
        tick();

        // Game 1: directed presses, then random presses until the player wins.
        begin_game();
        do_press(1'b0, 1'b1, 1'b1, 1'b0);
        do_press(1'b1, 1'b0, 1'b1, 1'b0);
        do_press(1'b1, 1'b1, 1'b1, 1'b0);
        do_press(1'b1, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (m_state == S_PLAY && guard < 400) begin
            sel = int'($urandom_range(0, 5));
            nb  = 1'($urandom_range(0, 1));
            if (sel == 5) do_press(1'b1, 1'b1, nb, 1'b0);
            else          do_press(sel[0], !sel[0], nb, 1'b0);
            guard++;
        end
        chk("game1_finished", game_state, S_DONE);
        do_press(1'b0, 1'b1, 1'b1, 1'b0);
        do_press(1'b1, 1'b0, 1'b0, 1'b0);
        end_game();

        // Game 2: PC finishes on the very cycle of the last correct press.
        begin_game();
        while (m_left > 1) correct_press(1'b0);
        correct_press(1'b1);
        end_game();

        // Game 3: PC finishes alone with boxes still left.
        begin_game();
        while (m_left > 5) correct_press(1'b0);
        pc_done = 1'b1;
        tick();
        pc_done  = 1'b0;
        m_state  = S_DONE;
        m_winner = W_PC;
        check_model("pc_win");
        end_game();

        // Game 4: timeout after TLIMIT seconds with no keys.
        begin_game();
        for (int k = 1; k <= TLIMIT; k++) begin
            sec_tick = 1'b1;
            tick();
            sec_tick = 1'b0;
            if (k == TLIMIT) begin
                m_state  = S_DONE;
                m_winner = W_TIME;
            end
            check_model("sec_tick");
            tick();
        end
        end_game();

        // Game 5: abort by dropping start mid-play.
        begin_game();
        correct_press(1'b0);
        end_game();

`ifdef RACE_PENALTY_EN
        // Game 6: a correct key inside the lockout window is ignored.
        begin_game();
        next_box = 1'b1;
        key_left = 1'b1;
        tick();
        tick();
        key_left = 1'b0;
        tick();
        tick();
        key_right = 1'b1;
        sel = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 2) key_right = 1'b0;
            if (shift_en) sel++;
        end
        $display("lockout press pulses=%0d left=%0d", sel, player_left);
        chk("lockout_pulses", sel, 0);
        chk("lockout_left", player_left, BOXES);
        repeat (PENALTY + 2) tick();
        do_press(1'b0, 1'b1, 1'b1, 1'b0);
        end_game();
`endif

        // Reset during play returns every output to its reset value.
        begin_game();
        correct_press(1'b0);
        resetn = 1'b0;
        tick();
        m_state  = S_IDLE;
        m_left   = BOXES;
        m_winner = W_NONE;
        check_model("midreset");
        chk("midreset_shift_en", shift_en, 0);
        chk("midreset_shift_load_n", shift_load_n, 0);
        start  = 1'b0;
        resetn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
